layer_dot_accum: RTL and testbench

- Parametrised fixed-point dot-product/accumulate engine, the successor to the fixed 8-lane, 16-bit layer MAC.
- Multiplies LANES input/weight pairs per beat, reduces them through a pipelined adder tree, and accumulates over a multi-beat group.
- At group end it adds bias, optionally applies ReLU, saturates to DATA_W and presents the result with a valid/ready handshake.
- Sits between the layer buffer/weight fetch and the activation write-back of the fully-connected layers.

---
 rtl/layer_dot_pkg.sv | 43 ++++
 rtl/layer_dot_accum_tree.sv | 29 ++
 rtl/layer_dot_accum.sv | 205 ++++++++++++++++++++
 tb/tb_layer_dot_accum.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/layer_dot_pkg.sv
// Shared types, default fixed-point format and saturation helpers for the
// layer dot-product/accumulate engine.
package layer_dot_pkg;

    // Default operand format: Q5.10 in 16 bits.
    localparam int DEF_DATA_W = 16;
    localparam int DEF_FRAC_W = 10;

    // Working width for saturation arithmetic; ACC_W must stay below this.
    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // Group tracking: IDLE means the next beat starts a fresh group.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Clamp v to the signed range of a w-bit two's-complement number.
    function automatic wide_t sat_signed(input wide_t v, input int unsigned w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    // Saturate an accumulated value to the output data width.
    function automatic wide_t sat_to_data(input wide_t acc, input int unsigned data_w);
        return sat_signed(acc, data_w);
    endfunction

    // Keep the running sum inside the accumulator range instead of wrapping.
    function automatic wide_t clamp_acc(input wide_t acc, input int unsigned acc_w);
        return sat_signed(acc, acc_w);
    endfunction

endpackage

// File: rtl/layer_dot_accum_tree.sv
// Balanced combinational adder tree; the parent registers the root.
module dot_adder_tree #(
    parameter int LANES = 8,
    parameter int ACC_W = 32
) (
    input  logic [LANES*ACC_W-1:0] terms_i,
    output logic [ACC_W-1:0]       sum_o
);

    localparam int LEVELS = $clog2(LANES);

    // Level l holds LANES >> l partial sums; level 0 is the lane products.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N = LANES >> l;
        logic signed [ACC_W-1:0] s [N];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_in
                assign s[i] = terms_i[i*ACC_W +: ACC_W];
            end
        end else begin : g_add
            for (genvar i = 0; i < N; i++) begin : g_pair
                assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
            end
        end
    end

    assign sum_o = g_lvl[LEVELS].s[0];

endmodule

// File: rtl/layer_dot_accum.sv
// Fixed-point dot-product/accumulate engine: LANES products per beat, a
// pipelined adder tree, multi-beat accumulation, then bias, optional ReLU and
// saturation to a single result behind a valid/ready handshake.
module layer_dot_accum
    import layer_dot_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [LANES*DATA_W-1:0] input_data,
    input  logic [LANES*DATA_W-1:0] weight_data,
    input  logic [DATA_W-1:0]       bias_data,
    input  logic                    relu_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       result_data_out,
    output logic [CNT_W-1:0]        beat_count,
    output logic                    protocol_err
);

    // Multiply width: wide enough for the full product and the accumulator.
    localparam int MW = (ACC_W > 2*DATA_W) ? ACC_W : 2*DATA_W;

    logic en;
    logic accept;

    state_t state_q, state_d;
    logic   eff_first;
    logic   perr_q, perr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic   cnt_clr_q, cnt_clr_d;

    logic [LANES*ACC_W-1:0] terms_d;

    logic                     s1_valid_q, s1_first_q, s1_last_q, s1_relu_q;
    logic signed [DATA_W-1:0] s1_bias_q;
    logic [LANES*ACC_W-1:0]   s1_terms_q;
    logic [ACC_W-1:0]         tree_sum;

    logic                     s2_valid_q, s2_first_q, s2_last_q, s2_relu_q;
    logic signed [DATA_W-1:0] s2_bias_q;
    logic signed [ACC_W-1:0]  s2_sum_q;

    logic signed [ACC_W-1:0]  acc_q;
    wide_t                    acc_next_w;
    wide_t                    res_w;
    logic                     load;
    logic                     out_valid_q;
    logic [DATA_W-1:0]        result_q;

    // The whole pipeline stalls only while a finished result is refused.
    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;
    assign accept   = in_valid && en;

    // Group FSM, sticky protocol error and beat counter next-state.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        perr_d    = perr_q;
        cnt_clr_d = 1'b0;
        cnt_d     = cnt_clr_q ? '0 : cnt_q;
        eff_first = in_first || (state_q == IDLE);
        if (accept) begin
            state_d = in_last ? IDLE : ACCUM;
            if (in_first && state_q == ACCUM) begin
                perr_d = 1'b1;
            end
            if (in_first) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_d != '1) begin
                cnt_d = cnt_d + CNT_W'(1);
            end
            cnt_clr_d = in_last;
        end
    end

    // Control registers: group state, error flag, beat counter.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            perr_q    <= 1'b0;
            cnt_q     <= '0;
            cnt_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            perr_q    <= perr_d;
            cnt_q     <= cnt_d;
            cnt_clr_q <= cnt_clr_d;
        end
    end

    // Lane products: full-width signed multiply, floor shift, fit to ACC_W.
    always_comb begin
        logic signed [MW-1:0] a_x;
        logic signed [MW-1:0] w_x;
        logic signed [MW-1:0] p;
        terms_d = '0;
        a_x     = '0;
        w_x     = '0;
        p       = '0;
        for (int i = 0; i < LANES; i++) begin
            a_x = {{(MW-DATA_W){input_data[i*DATA_W+DATA_W-1]}},
                   input_data[i*DATA_W +: DATA_W]};
            w_x = {{(MW-DATA_W){weight_data[i*DATA_W+DATA_W-1]}},
                   weight_data[i*DATA_W +: DATA_W]};
            p   = (a_x * w_x) >>> FRAC_W;
            terms_d[i*ACC_W +: ACC_W] = p[ACC_W-1:0];
        end
    end

    // S1: register lane products with the beat's side-band controls.
    // NOTE: the wide data registers are reset too; they are plain flops, not
    // a RAM, and a clean reset keeps the datapath free of X after power-up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_relu_q  <= 1'b0;
            s1_bias_q  <= '0;
            s1_terms_q <= '0;
        end else if (en) begin
            s1_valid_q <= accept;
            s1_first_q <= eff_first;
            s1_last_q  <= in_last;
            s1_relu_q  <= relu_en;
            s1_bias_q  <= bias_data;
            s1_terms_q <= terms_d;
        end
    end

    dot_adder_tree #(
        .LANES (LANES),
        .ACC_W (ACC_W)
    ) u_tree (
        .terms_i (s1_terms_q),
        .sum_o   (tree_sum)
    );

    // S2: register the adder-tree root.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_relu_q  <= 1'b0;
            s2_bias_q  <= '0;
            s2_sum_q   <= '0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            s2_relu_q  <= s1_relu_q;
            s2_bias_q  <= s1_bias_q;
            s2_sum_q   <= tree_sum;
        end
    end

    // S3 datapath: clamped accumulate, then bias, ReLU and output saturation.
    always_comb begin
        acc_next_w = clamp_acc((s2_first_q ? wide_t'(0) : wide_t'(acc_q)) + wide_t'(s2_sum_q),
                               ACC_W);
        res_w      = acc_next_w + wide_t'(s2_bias_q);
        if (s2_relu_q && res_w < 0) begin
            res_w = '0;
        end
        load = en && s2_valid_q && s2_last_q;
    end

    // S3 registers: accumulator, result and its valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (en) begin
            if (s2_valid_q) begin
                acc_q <= s2_last_q ? '0 : ACC_W'(acc_next_w);
            end
            out_valid_q <= load;
            if (load) begin
                result_q <= DATA_W'(sat_to_data(res_w, DATA_W));
            end
        end
    end

    assign out_valid       = out_valid_q;
    assign result_data_out = result_q;
    assign beat_count      = cnt_q;
    assign protocol_err    = perr_q;

endmodule

// File: tb/tb_layer_dot_accum.sv
// Directed scoreboard bench for layer_dot_accum (default parameters).
module tb_layer_dot_accum;

    localparam int LANES  = 8;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 12;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_first;
    logic                    in_last;
    logic [LANES*DATA_W-1:0] input_data;
    logic [LANES*DATA_W-1:0] weight_data;
    logic [DATA_W-1:0]       bias_data;
    logic                    relu_en;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       result_data_out;
    logic [CNT_W-1:0]        beat_count;
    logic                    protocol_err;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    layer_dot_accum #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .FRAC_W (10),
        .ACC_W  (32),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_first        (in_first),
        .in_last         (in_last),
        .input_data      (input_data),
        .weight_data     (weight_data),
        .bias_data       (bias_data),
        .relu_en         (relu_en),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .result_data_out (result_data_out),
        .beat_count      (beat_count),
        .protocol_err    (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one beat with every lane set to a*w; queue the expected result on
    // a last beat once the DUT has accepted it.
    task automatic send(input logic [15:0] a, input logic [15:0] w,
                        input logic first, input logic last,
                        input logic [15:0] bias, input logic relu,
                        input logic [15:0] exp);
        int n;
        @(negedge clk);
        input_data  = {LANES{a}};
        weight_data = {LANES{w}};
        in_first    = first;
        in_last     = last;
        bias_data   = bias;
        relu_en     = relu;
        in_valid    = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        if (last) exp_q.push_back(exp);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for every queued result to be consumed.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: compare each handshaken result against the oldest expectation.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra: observed result %h expected no output", result_data_out);
            end
            if (exp_q.size() != 0) begin
                check("sb_result", 32'(result_data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_first    = 1'b0;
        in_last     = 1'b0;
        input_data  = '0;
        weight_data = '0;
        bias_data   = '0;
        relu_en     = 1'b0;
        out_ready   = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result_data_out), 32'd0);
        check("rst_beat_count", 32'(beat_count), 32'd0);
        check("rst_perr", 32'(protocol_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Single-beat group 8 x (1.0*1.0) = 8.0, with latency and counter checks.
        send(16'h0400, 16'h0400, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h2000);
        check("t1_count_1", 32'(beat_count), 32'd1);
        check("t1_valid_t1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_count_0", 32'(beat_count), 32'd0);
        check("t1_valid_t2", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_valid_t3", 32'(out_valid), 32'd1);
        check("t1_result", 32'(result_data_out), 32'h2000);
        drain("t1_drain");

        // Three-beat group with bias 0.5 -> 24.5.
        send(16'h0400, 16'h0400, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("t2_count_1", 32'(beat_count), 32'd1);
        send(16'h0400, 16'h0400, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("t2_count_2", 32'(beat_count), 32'd2);
        check("t2_no_valid", 32'(out_valid), 32'd0);
        send(16'h0400, 16'h0400, 1'b0, 1'b1, 16'h0200, 1'b0, 16'h6200);
        check("t2_count_3", 32'(beat_count), 32'd3);
        drain("t2_drain");

        // Positive and negative saturation.
        send(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h7FFF);
        send(16'h8000, 16'h7FFF, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h8000);
        drain("t3_drain");

        // Negative result without and with ReLU.
        send(16'h0400, 16'hFC00, 1'b1, 1'b1, 16'h0000, 1'b0, 16'hE000);
        send(16'h0400, 16'hFC00, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000);
        drain("t4_drain");

        // Group opened without in_first after a last beat starts from zero.
        send(16'h0400, 16'h0400, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        send(16'h0400, 16'h0400, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h4000);
        drain("t5_drain");

        // Backpressure: hold out_ready low while streaming four single-beat groups.
        @(posedge clk); #2;
        out_ready = 1'b0;
        fork
            begin
                send(16'h0400, 16'h0400, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h2000);
                send(16'h0400, 16'hFC00, 1'b1, 1'b1, 16'h0000, 1'b0, 16'hE000);
                send(16'h0200, 16'h0400, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h1000);
                send(16'h0400, 16'h0400, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h2100);
            end
            begin
                repeat (6) @(negedge clk);
                check("t6_in_ready_low", 32'(in_ready), 32'd0);
                check("t6_valid_held", 32'(out_valid), 32'd1);
                check("t6_result_held", 32'(result_data_out), 32'h2000);
                repeat (3) @(negedge clk);
                check("t6_result_still", 32'(result_data_out), 32'h2000);
                @(posedge clk); #2;
                out_ready = 1'b1;
            end
        join
        drain("t6_drain");

        // in_first mid-group restarts the sum and raises the sticky error.
        check("t7_perr_before", 32'(protocol_err), 32'd0);
        send(16'h0400, 16'h0400, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        send(16'h0400, 16'h0400, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        send(16'h0200, 16'h0400, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("t7_perr_set", 32'(protocol_err), 32'd1);
        check("t7_count_restart", 32'(beat_count), 32'd1);
        send(16'h0400, 16'h0400, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h3000);
        drain("t7_drain");

        // Asynchronous reset mid-group discards the partial sum.
        send(16'h0400, 16'h0400, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        send(16'h0400, 16'h0400, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("t8_valid", 32'(out_valid), 32'd0);
        check("t8_result", 32'(result_data_out), 32'd0);
        check("t8_count", 32'(beat_count), 32'd0);
        check("t8_perr", 32'(protocol_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send(16'h0400, 16'hFC00, 1'b0, 1'b1, 16'h0000, 1'b0, 16'hE000);
        drain("t8_drain");

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
